// File: rtl/spi_ram_responder.sv
// spi_ram_responder: mode-0 SPI slave serving READ/WRITE word frames
// from on-chip memory, with a host preload and inspect port.
module spi_ram_responder #(
   parameter int ADDR_W    = 8,
   parameter int INIT_ZERO = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_cs,
   input  logic              spi_sck,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [15:0]       host_wdata,
   output logic [15:0]       host_rdata,
   output logic              busy,
   output logic              frame_done,
   output logic              cmd_err
);
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      RD_LOAD,
      RD_DATA,
      WR_DATA,
      IGNORE
   } state_t;

   state_t            state;
   logic [3:0]        bit_cnt;
   logic [15:0]       rx_sr;
   logic [15:0]       rx_next;
   logic [15:0]       tx_sr;
   logic [15:0]       wr_word;
   logic [ADDR_W-1:0] addr;
   logic              is_read;
   logic              wr_pend;

   logic [1:0]        cs_sync;
   logic [1:0]        sck_sync;
   logic [1:0]        mosi_sync;
   logic              cs_q;
   logic              sck_q;
   logic              cs_fall;
   logic              cs_rise;
   logic              sck_rise;
   logic              sck_fall;
   logic              mosi_s;
   logic              cmd_rd;
   logic              cmd_wr;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [15:0]       mem_wdata;
   logic [ADDR_W-1:0] spi_raddr;
   logic [15:0]       spi_rd;
   logic [15:0]       host_rd;

   // CS resets to "asserted" so a CS held low across reset
   // never looks like a fresh falling edge afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         cs_sync   <= '0;
         sck_sync  <= '0;
         mosi_sync <= '0;
         cs_q      <= 1'b0;
         sck_q     <= 1'b0;
      end else begin
         cs_sync   <= {cs_sync[0], spi_cs};
         sck_sync  <= {sck_sync[0], spi_sck};
         mosi_sync <= {mosi_sync[0], spi_mosi};
         cs_q      <= cs_sync[1];
         sck_q     <= sck_sync[1];
      end
   end

   assign cs_fall  = cs_q & ~cs_sync[1];
   assign cs_rise  = ~cs_q & cs_sync[1];
   assign sck_rise = ~sck_q & sck_sync[1];
   assign sck_fall = sck_q & ~sck_sync[1];
   assign mosi_s   = mosi_sync[1];

   assign rx_next = {rx_sr[14:0], mosi_s};
   assign cmd_rd  = (rx_next[7:0] == 8'h03);
   assign cmd_wr  = (rx_next[7:0] == 8'h02);

   // SPI writes only happen while busy, so they never meet a host write.
   assign mem_we    = (wr_pend & ~rst) | (host_we & ~busy);
   assign mem_waddr = wr_pend ? addr : host_addr;
   assign mem_wdata = wr_pend ? wr_word : host_wdata;
   assign spi_raddr = (state == RD_LOAD) ? addr : addr + 1'b1;

   if (INIT_ZERO != 0) begin : g_mem_zero
      logic [15:0] mem [DEPTH] = '{default: 16'h0000};

      always @(posedge clk) begin
         if (mem_we) mem[mem_waddr] <= mem_wdata;
      end

      assign spi_rd  = mem[spi_raddr];
      assign host_rd = mem[host_addr];
   end else begin : g_mem
      logic [15:0] mem [DEPTH];

      always @(posedge clk) begin
         if (mem_we) mem[mem_waddr] <= mem_wdata;
      end

      assign spi_rd  = mem[spi_raddr];
      assign host_rd = mem[host_addr];
   end

   always_ff @(posedge clk) begin
      if (rst) host_rdata <= '0;
      else     host_rdata <= host_rd;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         rx_sr       <= '0;
         tx_sr       <= '0;
         wr_word     <= '0;
         addr        <= '0;
         is_read     <= 1'b0;
         wr_pend     <= 1'b0;
         spi_miso    <= 1'b0;
         spi_miso_oe <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         cmd_err     <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         cmd_err    <= 1'b0;
         wr_pend    <= 1'b0;
         if (cs_rise) begin
            if (state != IDLE) frame_done <= 1'b1;
            state       <= IDLE;
            bit_cnt     <= '0;
            busy        <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (cs_fall) begin
                     state   <= CMD;
                     bit_cnt <= '0;
                     busy    <= 1'b1;
                  end
               end
               CMD: begin
                  if (sck_rise) begin
                     rx_sr   <= rx_next;
                     bit_cnt <= bit_cnt + 1'b1;
                     if (bit_cnt == 4'd7) begin
                        bit_cnt <= '0;
                        unique case (1'b1)
                           cmd_rd: begin
                              is_read <= 1'b1;
                              state   <= ADDR;
                           end
                           cmd_wr: begin
                              is_read <= 1'b0;
                              state   <= ADDR;
                           end
                           default: begin
                              state   <= IGNORE;
                              cmd_err <= 1'b1;
                           end
                        endcase
                     end
                  end
               end
               ADDR: begin
                  if (sck_rise) begin
                     rx_sr   <= rx_next;
                     bit_cnt <= bit_cnt + 1'b1;
                     if (bit_cnt == 4'd15) begin
                        bit_cnt <= '0;
                        addr    <= rx_next[ADDR_W-1:0];
                        state   <= is_read ? RD_LOAD : WR_DATA;
                     end
                  end
               end
               RD_LOAD: begin
                  tx_sr       <= spi_rd;
                  spi_miso    <= spi_rd[15];
                  spi_miso_oe <= 1'b1;
                  bit_cnt     <= '0;
                  state       <= RD_DATA;
               end
               RD_DATA: begin
                  // bit_cnt == 0 means no rise yet for this word:
                  // the fall re-drives bit 15 instead of shifting.
                  if (sck_rise) begin
                     if (bit_cnt == 4'd15) begin
                        bit_cnt <= '0;
                        addr    <= addr + 1'b1;
                        tx_sr   <= spi_rd;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end else if (sck_fall) begin
                     if (bit_cnt != 4'd0) begin
                        tx_sr    <= {tx_sr[14:0], 1'b0};
                        spi_miso <= tx_sr[14];
                     end else begin
                        spi_miso <= tx_sr[15];
                     end
                  end
               end
               WR_DATA: begin
                  if (wr_pend) addr <= addr + 1'b1;
                  if (sck_rise) begin
                     rx_sr   <= rx_next;
                     bit_cnt <= bit_cnt + 1'b1;
                     if (bit_cnt == 4'd15) begin
                        bit_cnt <= '0;
                        wr_word <= rx_next;
                        wr_pend <= 1'b1;
                     end
                  end
               end
               IGNORE: begin
                  spi_miso    <= 1'b0;
                  spi_miso_oe <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
